// File: rtl/fram_otp_ctrl.sv
// fram_otp_ctrl
// Gives a single-port FRAM macro one-time-programmable behaviour and shares
// it between the CPU bus and the boot-time signature checker (read only).
// Every CPU write becomes read-merge-write, so a stored bit can only go
// from 0 to 1. A lock word, reloaded from FRAM after every reset, freezes
// the whole array against further CPU writes.
//
// Ports
//   clk, reset              system clock, synchronous active-high reset
//   cpu_valid/addr/wdata/wstrb   CPU request, held until cpu_ready; wstrb=0 is a read
//   cpu_ready/rdata/err     one-cycle completion; rdata is read data or merged word
//   boot_valid/addr         checker read request, held until boot_ready
//   boot_ready/rdata        one-cycle completion with read data
//   fram_en/we/addr/wdata   macro access (word address), fram_rdata one cycle after a read
//   locked                  array locked
module fram_otp_ctrl #(
   parameter int                        FRAM_ADDR_BITS = 12,
   parameter logic [FRAM_ADDR_BITS-1:0] LOCK_ADDR      = 12'hFFC
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      cpu_valid,
   input  logic [FRAM_ADDR_BITS-1:0] cpu_addr,
   input  logic [31:0]               cpu_wdata,
   input  logic [3:0]                cpu_wstrb,
   output logic                      cpu_ready,
   output logic [31:0]               cpu_rdata,
   output logic                      cpu_err,
   input  logic                      boot_valid,
   input  logic [FRAM_ADDR_BITS-1:0] boot_addr,
   output logic                      boot_ready,
   output logic [31:0]               boot_rdata,
   output logic                      fram_en,
   output logic [3:0]                fram_we,
   output logic [FRAM_ADDR_BITS-3:0] fram_addr,
   output logic [31:0]               fram_wdata,
   input  logic [31:0]               fram_rdata,
   output logic                      locked
);

   localparam int WA = FRAM_ADDR_BITS - 2;
   localparam logic [WA-1:0] LOCK_WORD = LOCK_ADDR[FRAM_ADDR_BITS-1:2];

   typedef enum logic [2:0] {
      INIT_RD,
      INIT_LD,
      IDLE,
      RD,
      MERGE,
      RESP
   } state_t;

   state_t          state_reg, state_next;
   logic            locked_reg;
   logic            last_boot_reg;   // 1 = boot was served last
   logic            gnt_boot_reg;    // current transaction belongs to boot
   logic [WA-1:0]   addr_reg;
   logic [31:0]     wdata_reg;
   logic [3:0]      wstrb_reg;       // forced to 0 for boot, so boot is always a read
   logic            err_reg;
   logic [31:0]     merged_reg;

   logic            grant;
   logic            grant_boot;
   logic            cpu_is_write;
   logic [31:0]     byte_mask;
   logic [31:0]     merged_w;
   logic            clear_w;

   // Byte-address bits below the word are ignored.
   logic            unused_addr_bits;
   assign unused_addr_bits = ^{cpu_addr[1:0], boot_addr[1:0]};

   assign cpu_is_write = (cpu_wstrb != 4'h0);

   for (genvar gi = 0; gi < 4; gi++) begin : g_mask
      assign byte_mask[gi*8 +: 8] = {8{wstrb_reg[gi]}};
   end

   // Old word arrives on fram_rdata during MERGE; bits may only be set.
   assign merged_w = fram_rdata | (wdata_reg & byte_mask);
   assign clear_w  = |(fram_rdata & ~wdata_reg & byte_mask);

   // Next state and arbitration
   always_comb begin
      state_next = state_reg;
      grant      = 1'b0;
      grant_boot = 1'b0;
      case (state_reg)
         INIT_RD: state_next = INIT_LD;
         INIT_LD: state_next = IDLE;
         IDLE: begin
            // On a tie the requester not served last wins.
            if (boot_valid && (!cpu_valid || !last_boot_reg)) begin
               grant      = 1'b1;
               grant_boot = 1'b1;
               state_next = RD;
            end else if (cpu_valid) begin
               grant      = 1'b1;
               state_next = (locked_reg && cpu_is_write) ? RESP : RD;
            end
         end
         RD:      state_next = (wstrb_reg == 4'h0) ? RESP : MERGE;
         MERGE:   state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = INIT_RD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= INIT_RD;
         locked_reg    <= 1'b0;
         last_boot_reg <= 1'b0;
         gnt_boot_reg  <= 1'b0;
         addr_reg      <= '0;
         wdata_reg     <= '0;
         wstrb_reg     <= '0;
         err_reg       <= 1'b0;
         merged_reg    <= '0;
      end else begin
         state_reg <= state_next;
         if (state_reg == INIT_LD) begin
            locked_reg <= fram_rdata[0];
         end
         if (grant) begin
            gnt_boot_reg  <= grant_boot;
            last_boot_reg <= grant_boot;
            addr_reg      <= grant_boot ? boot_addr[FRAM_ADDR_BITS-1:2] : cpu_addr[FRAM_ADDR_BITS-1:2];
            wdata_reg     <= grant_boot ? 32'h0 : cpu_wdata;
            wstrb_reg     <= grant_boot ? 4'h0 : cpu_wstrb;
            // A CPU write while locked completes immediately as an error.
            err_reg       <= !grant_boot && locked_reg && cpu_is_write;
            merged_reg    <= '0;
         end
         if (state_reg == MERGE) begin
            merged_reg <= merged_w;
            err_reg    <= clear_w;
            // Registered here so that locked is already high during RESP.
            if ((addr_reg == LOCK_WORD) && merged_w[0]) begin
               locked_reg <= 1'b1;
            end
         end
      end
   end

   // Outputs are forced quiet while reset is asserted so an in-flight
   // write or completion pulse is dropped in that same cycle.
   always_comb begin
      fram_en    = 1'b0;
      fram_we    = 4'h0;
      fram_addr  = '0;
      fram_wdata = 32'h0;
      cpu_ready  = 1'b0;
      cpu_rdata  = 32'h0;
      cpu_err    = 1'b0;
      boot_ready = 1'b0;
      boot_rdata = 32'h0;
      if (!reset) begin
         case (state_reg)
            INIT_RD: begin
               fram_en   = 1'b1;
               fram_addr = LOCK_WORD;
            end
            RD: begin
               fram_en   = 1'b1;
               fram_addr = addr_reg;
            end
            MERGE: begin
               fram_addr = addr_reg;
               // Skip the write cycle when nothing would change.
               if (merged_w != fram_rdata) begin
                  fram_en    = 1'b1;
                  fram_we    = 4'hF;
                  fram_wdata = merged_w;
               end
            end
            RESP: begin
               if (gnt_boot_reg) begin
                  boot_ready = 1'b1;
                  boot_rdata = fram_rdata;
               end else begin
                  cpu_ready = 1'b1;
                  cpu_err   = err_reg;
                  cpu_rdata = (wstrb_reg == 4'h0) ? fram_rdata : merged_reg;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign locked = locked_reg;

endmodule

// File: tb/tb_fram_otp_ctrl.sv
// tb_fram_otp_ctrl
// Self-checking bench for fram_otp_ctrl. A simple FRAM macro model sits on
// the memory side; a reference model (word array plus lock flag) applies the
// OTP rules per transaction and predicts data, error, latency and whether a
// write reaches the macro. Directed cases pin the model with literal values.
module tb_fram_otp_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cpu_valid = 1'b0;
   logic [11:0] cpu_addr = 12'h0;
   logic [31:0] cpu_wdata = 32'h0;
   logic [3:0]  cpu_wstrb = 4'h0;
   logic        cpu_ready;
   logic [31:0] cpu_rdata;
   logic        cpu_err;
   logic        boot_valid = 1'b0;
   logic [11:0] boot_addr = 12'h0;
   logic        boot_ready;
   logic [31:0] boot_rdata;
   logic        fram_en;
   logic [3:0]  fram_we;
   logic [9:0]  fram_addr;
   logic [31:0] fram_wdata;
   logic [31:0] fram_rdata;
   logic        locked;

   int          checks = 0;
   int          errors = 0;

   logic [31:0] fram_mem [0:1023];
   logic [31:0] ref_mem  [0:1023];
   logic        ref_locked = 1'b0;
   logic [31:0] last_rdata;
   logic        last_err;

   logic        bd_we = 1'b0;
   logic [9:0]  bd_addr = 10'h0;
   logic [31:0] bd_data = 32'h0;

   always #5 clk = ~clk;

   fram_otp_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .cpu_valid  (cpu_valid),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_wstrb  (cpu_wstrb),
      .cpu_ready  (cpu_ready),
      .cpu_rdata  (cpu_rdata),
      .cpu_err    (cpu_err),
      .boot_valid (boot_valid),
      .boot_addr  (boot_addr),
      .boot_ready (boot_ready),
      .boot_rdata (boot_rdata),
      .fram_en    (fram_en),
      .fram_we    (fram_we),
      .fram_addr  (fram_addr),
      .fram_wdata (fram_wdata),
      .fram_rdata (fram_rdata),
      .locked     (locked)
   );

   // FRAM macro: registered read, byte-enabled write, plus a bench back door.
   always @(posedge clk) begin
      if (bd_we) begin
         fram_mem[bd_addr] <= bd_data;
      end else if (fram_en) begin
         if (fram_we == 4'h0) begin
            fram_rdata <= fram_mem[fram_addr];
         end else begin
            for (int b = 0; b < 4; b++) begin
               if (fram_we[b]) fram_mem[fram_addr][b*8 +: 8] <= fram_wdata[b*8 +: 8];
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Called at posedge+1; leaves at posedge+1.
   task automatic bd_write(input int w, input logic [31:0] d);
      bd_we   = 1'b1;
      bd_addr = 10'(w);
      bd_data = d;
      ref_mem[w] = d;
      @(posedge clk);
      #1 bd_we = 1'b0;
   endtask

   // Reset, then walk the two init cycles; returns in IDLE at posedge+1.
   task automatic do_reset();
      reset      = 1'b1;
      cpu_valid  = 1'b0;
      boot_valid = 1'b0;
      cpu_wstrb  = 4'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_cpu_ready", 32'(cpu_ready), 32'd0);
      chk("rst_boot_ready", 32'(boot_ready), 32'd0);
      chk("rst_fram_en", 32'(fram_en), 32'd0);
      chk("rst_fram_we", 32'(fram_we), 32'd0);
      chk("rst_locked", 32'(locked), 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("init_rd_en", 32'(fram_en), 32'd1);
      chk("init_rd_we", 32'(fram_we), 32'd0);
      chk("init_rd_addr", 32'(fram_addr), 32'h3FF);
      chk("init_cpu_ready", 32'(cpu_ready), 32'd0);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("init_locked", 32'(locked), 32'(ref_locked));
      @(posedge clk);
      #1;
   endtask

   // One transaction from a single requester, started in IDLE at posedge+1.
   // The model computes the outcome, then every cycle up to completion is compared.
   task automatic run_txn(input bit is_boot, input logic [11:0] addr,
                          input logic [31:0] wd, input logic [3:0] ws);
      int          w;
      int          lat;
      logic [31:0] old, mask, exp_rd;
      logic        exp_err, exp_write, chk_rd, no_access;
      logic        seen_we, seen_en;
      w         = int'(addr[11:2]);
      old       = ref_mem[w];
      exp_rd    = old;
      exp_err   = 1'b0;
      exp_write = 1'b0;
      chk_rd    = 1'b1;
      no_access = 1'b0;
      lat       = 2;
      mask      = 32'h0;
      if (!is_boot && ws != 4'h0) begin
         if (ref_locked) begin
            lat       = 1;
            exp_err   = 1'b1;
            chk_rd    = 1'b0;
            no_access = 1'b1;
         end else begin
            for (int b = 0; b < 4; b++) mask[b*8 +: 8] = ws[b] ? 8'hFF : 8'h00;
            exp_rd    = old | (wd & mask);
            exp_err   = |(old & ~wd & mask);
            exp_write = (exp_rd != old);
            ref_mem[w] = exp_rd;
            if (w == 1023 && exp_rd[0]) ref_locked = 1'b1;
            lat = 3;
         end
      end
      if (is_boot) begin
         boot_valid = 1'b1;
         boot_addr  = addr;
      end else begin
         cpu_valid = 1'b1;
         cpu_addr  = addr;
         cpu_wdata = wd;
         cpu_wstrb = ws;
      end
      seen_we = 1'b0;
      seen_en = 1'b0;
      for (int c = 0; c <= lat; c++) begin
         @(negedge clk);
         if (fram_we != 4'h0) seen_we = 1'b1;
         if (fram_en) seen_en = 1'b1;
         if (c == 1 && !no_access) chk("rd_addr", 32'(fram_addr), 32'(w));
         if (c == 2 && exp_write) begin
            chk("we_cycle2", 32'(fram_we), 32'hF);
            chk("wdata", fram_wdata, exp_rd);
         end
         if (c < lat) begin
            chk("early_ready", 32'({cpu_ready, boot_ready}), 32'd0);
            chk("idle_rdata", cpu_rdata | boot_rdata, 32'h0);
            @(posedge clk);
         end else begin
            chk("ready_cpu", 32'(cpu_ready), 32'(!is_boot));
            chk("ready_boot", 32'(boot_ready), 32'(is_boot));
            last_rdata = is_boot ? boot_rdata : cpu_rdata;
            last_err   = cpu_err;
            if (chk_rd) chk("rdata", last_rdata, exp_rd);
            if (!is_boot) chk("err", 32'(cpu_err), 32'(exp_err));
            chk("locked", 32'(locked), 32'(ref_locked));
         end
      end
      chk("fram_write", 32'(seen_we), 32'(exp_write));
      if (no_access) chk("no_fram_en", 32'(seen_en), 32'd0);
      $display("txn %s addr=%h wdata=%h wstrb=%h -> rdata=%h err=%0d locked=%0d",
               is_boot ? "boot" : "cpu ", addr, wd, ws, last_rdata, last_err, locked);
      @(posedge clk);
      #1;
      cpu_valid  = 1'b0;
      boot_valid = 1'b0;
   endtask

   task automatic run_random(input int n);
      int          kind;
      logic [11:0] a;
      logic [31:0] d;
      logic [3:0]  s;
      for (int i = 0; i < n; i++) begin
         kind = $urandom_range(0, 2);
         a    = {4'h0, 6'($urandom_range(32, 63)), 2'($urandom)};
         d    = $urandom & $urandom;
         s    = 4'($urandom_range(1, 15));
         case (kind)
            0:       run_txn(1'b1, a, 32'h0, 4'h0);
            1:       run_txn(1'b0, a, 32'h0, 4'h0);
            default: run_txn(1'b0, a, d, s);
         endcase
      end
   endtask

   // Both requesters held; grants must alternate starting with boot.
   task automatic run_arbitration();
      logic exp_boot;
      int   waited;
      cpu_valid  = 1'b1;
      cpu_addr   = 12'h010;
      cpu_wstrb  = 4'h0;
      boot_valid = 1'b1;
      boot_addr  = 12'h040;
      exp_boot   = 1'b1;
      for (int g = 0; g < 6; g++) begin
         waited = 0;
         @(negedge clk);
         while (!cpu_ready && !boot_ready && waited < 8) begin
            @(negedge clk);
            waited++;
         end
         chk("arb_spacing", 32'(waited), 32'd2);
         chk("arb_boot_ready", 32'(boot_ready), 32'(exp_boot));
         chk("arb_cpu_ready", 32'(cpu_ready), 32'(!exp_boot));
         if (exp_boot) chk("arb_boot_rdata", boot_rdata, ref_mem[16]);
         else          chk("arb_cpu_rdata", cpu_rdata, ref_mem[4]);
         $display("txn arb grant %0d -> %s", g, boot_ready ? "boot" : (cpu_ready ? "cpu" : "none"));
         exp_boot = !exp_boot;
      end
      @(posedge clk);
      #1;
      cpu_valid  = 1'b0;
      boot_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 1024; i++) begin
         bd_write(i, $urandom & $urandom);
      end
      bd_write(1023, 32'h0);
      bd_write(4, 32'hDEADBEEF);
      bd_write(5, 32'h0F0F0000);
      bd_write(8, 32'h0);
      do_reset();

      run_arbitration();

      run_txn(1'b0, 12'h010, 32'h0, 4'h0);
      chk("lit_read_deadbeef", last_rdata, 32'hDEADBEEF);
      chk("lit_read_err", 32'(last_err), 32'd0);
      chk("lit_unlocked", 32'(locked), 32'd0);

      run_txn(1'b0, 12'h014, 32'h00FF00FF, 4'hF);
      chk("lit_merge1", last_rdata, 32'h0FFF00FF);
      run_txn(1'b0, 12'h014, 32'h0, 4'hF);
      chk("lit_merge2_rdata", last_rdata, 32'h0FFF00FF);
      chk("lit_merge2_err", 32'(last_err), 32'd1);

      run_txn(1'b0, 12'h020, 32'hFFFFFFFF, 4'h1);
      chk("lit_strb_rdata", last_rdata, 32'h000000FF);
      chk("lit_strb_err", 32'(last_err), 32'd0);
      run_txn(1'b0, 12'h020, 32'hFFFFFFFF, 4'h1);
      chk("lit_rewrite_err", 32'(last_err), 32'd0);

      run_random(60);

      run_txn(1'b0, 12'hFFC, 32'h1, 4'h1);
      chk("lit_lock_set", 32'(locked), 32'd1);
      run_txn(1'b0, 12'h010, 32'hFFFFFFFF, 4'hF);
      chk("lit_locked_err", 32'(last_err), 32'd1);
      run_txn(1'b1, 12'h010, 32'h0, 4'h0);
      chk("lit_locked_boot", last_rdata, 32'hDEADBEEF);
      run_random(20);

      do_reset();
      chk("lit_lock_reload", 32'(locked), 32'd1);

      reset = 1'b1;
      bd_write(1023, 32'h0);
      ref_locked = 1'b0;
      do_reset();
      chk("lit_lock_cleared", 32'(locked), 32'd0);

      // Reset landing on the merge cycle must suppress the write.
      bd_write(20, 32'h00F00F00);
      cpu_valid = 1'b1;
      cpu_addr  = 12'h050;
      cpu_wdata = 32'hFFFFFFFF;
      cpu_wstrb = 4'hF;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset     = 1'b1;
      cpu_valid = 1'b0;
      @(negedge clk);
      chk("rst_merge_we", 32'(fram_we), 32'd0);
      chk("rst_merge_ready", 32'(cpu_ready), 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk("rst_merge_ready2", 32'(cpu_ready), 32'd0);
      chk("rst_merge_mem", fram_mem[20], 32'h00F00F00);
      @(posedge clk);
      #1;
      do_reset();
      run_txn(1'b0, 12'h050, 32'h0, 4'h0);
      chk("lit_after_rst_merge", last_rdata, 32'h00F00F00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
